// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - master-side and slave-side Wishbone bundle around wb_rr_arbiter
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int DATA_WIDTH  = 8
);
    logic [NUM_MASTERS-1:0]            m_cyc_i;
    logic [NUM_MASTERS-1:0]            m_stb_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_err_o;
    logic [DATA_WIDTH-1:0]             m_dat_o;
    logic                              s_cyc_o;
    logic                              s_stb_o;
    logic                              s_we_o;
    logic [ADDR_WIDTH-1:0]             s_adr_o;
    logic [DATA_WIDTH-1:0]             s_dat_o;
    logic                              s_ack_i;
    logic [DATA_WIDTH-1:0]             s_dat_i;
    logic [NUM_MASTERS-1:0]            gnt_o;
    logic                              busy_o;

    // Arbiter view: requests and slave responses in, shared bus and grant out.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output gnt_o, busy_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  gnt_o, busy_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - N-to-1 Wishbone round-robin arbiter granting whole cyc tenures
// Optional stalled-strobe timeout with ABORT state when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_rr_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
        ,
        ABORT = 2'd2
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       owner_inc;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic                   own;
    logic                   bus_live;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       stall_cnt_q;
    logic                   timeout;
`endif

    function automatic logic [IDX_W-1:0] cand_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return IDX_W'(s);
    endfunction

    // Walk downward so the candidate closest to ptr (offset 0) wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (bus.m_cyc_i[cand_idx(ptr_q, i)]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx(ptr_q, i);
            end
        end
    end

    assign owner_inc = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d         = OWN;
                    owner_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                end
            end
            OWN: begin
                if (!bus.m_cyc_i[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_inc;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_d = ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!bus.m_cyc_i[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_inc;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign own = (state_q == OWN);

`ifdef WB_ARB_TIMEOUT_EN
    // Counts stalled strobe cycles; at the limit the bus is dropped for one cycle before ABORT.
    assign timeout = own && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (state_d != OWN || bus.s_ack_i) begin
            stall_cnt_q <= '0;
        end else if (bus.s_stb_o) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus_live    = own & ~timeout;
    assign bus.m_err_o = timeout ? gnt_q : '0;
`else
    assign bus_live    = own;
    assign bus.m_err_o = '0;
`endif

    assign bus.s_cyc_o = bus_live;
    assign bus.s_stb_o = bus_live & bus.m_stb_i[owner_q];
    assign bus.s_we_o  = bus_live & bus.m_we_i[owner_q];
    assign bus.s_adr_o = bus_live ? bus.m_adr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.s_dat_o = bus_live ? bus.m_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.m_ack_o = bus_live ? (gnt_q & {NUM_MASTERS{bus.s_ack_i}}) : '0;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.gnt_o   = gnt_q;
    assign bus.busy_o  = (state_q != IDLE);
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking scoreboard bench for wb_rr_arbiter
`timescale 1ns/1ps
module tb_wb_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    wb_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                              input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        bus.m_cyc_i[k]          = cyc;
        bus.m_stb_i[k]          = stb;
        bus.m_we_i[k]           = we;
        bus.m_adr_i[k*AW +: AW] = adr;
        bus.m_dat_i[k*DW +: DW] = dat;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i       = 1'b0;
        bus.m_cyc_i = 4'hF;
        bus.m_stb_i = 4'hF;
        bus.m_we_i  = 4'hF;
        bus.m_adr_i = 8'hFF;
        bus.m_dat_i = 32'hFFFF_FFFF;
        bus.s_ack_i = 1'b1;
        tick();
        tick();
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%h exp=0", bus.gnt_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
        checks++; if ({bus.s_adr_o, bus.s_dat_o} !== 10'd0) begin failures++; $display("FAIL reset_adr_dat got=%h exp=0", {bus.s_adr_o, bus.s_dat_o}); end
        checks++; if ({bus.m_ack_o, bus.m_err_o} !== 8'd0) begin failures++; $display("FAIL reset_ack_err got=%h exp=0", {bus.m_ack_o, bus.m_err_o}); end
        idle_inputs();
    endtask

    task automatic test_single_write();
        logic [31:0] exp;
        do_reset();
        set_master(1, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
        sb_q.push_back({21'd0, 1'b1, 2'd2, 8'hA5});
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL single_no_early_gnt got=%h exp=0", bus.gnt_o); end
        tick();
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL single_gnt got=%h exp=2", bus.gnt_o); end
        checks++; if ({bus.s_cyc_o, bus.busy_o} !== 2'b11) begin failures++; $display("FAIL single_cyc_busy got=%b exp=11", {bus.s_cyc_o, bus.busy_o}); end
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m_ack_o !== 4'b0010) begin failures++; $display("FAIL single_ack got=%h exp=2", bus.m_ack_o); end
        exp = sb_q.pop_front();
        checks++; if ({21'd0, bus.s_we_o, bus.s_adr_o, bus.s_dat_o} !== exp) begin failures++; $display("FAIL single_write_beat got=%h exp=%h", {bus.s_we_o, bus.s_adr_o, bus.s_dat_o}, exp); end
        tick();
        bus.s_ack_i = 1'b0;
        set_master(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        #1;
        checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL single_ack_mirror_low got=%h exp=0", bus.m_ack_o); end
        tick();
        checks++; if ({bus.gnt_o, bus.s_cyc_o} !== 5'd0) begin failures++; $display("FAIL single_release got=%h exp=0", {bus.gnt_o, bus.s_cyc_o}); end
    endtask

    task automatic test_round_robin();
        int g;
        int gap;
        logic [N-1:0] exp_mask;
        logic [DW-1:0] rd;
        do_reset();
        sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2); sb_q.push_back(3); sb_q.push_back(0);
        bus.m_cyc_i = 4'hF;
        for (int t = 0; t < 5; t++) begin
            gap = 0;
            while (bus.gnt_o == '0 && gap < 10) begin
                gap++;
                tick();
            end
            checks++; if (gap !== 1) begin failures++; $display("FAIL rr_dead_cycles tenure=%0d got=%0d exp=1", t, gap); end
            g = (sb_q.size() > 0) ? int'(sb_q.pop_front()) : 0;
            exp_mask = '0;
            exp_mask[g] = 1'b1;
            checks++; if (bus.gnt_o !== exp_mask) begin failures++; $display("FAIL rr_order tenure=%0d got=%h exp=%h", t, bus.gnt_o, exp_mask); end
            for (int b = 0; b < 3; b++) begin
                rd = DW'($urandom);
                set_master(g, 1'b1, 1'b1, 1'b0, AW'(b), 8'h00);
                bus.s_ack_i = 1'b1;
                bus.s_dat_i = rd;
                #1;
                checks++; if ({bus.s_cyc_o, bus.m_ack_o, bus.m_dat_o} !== {1'b1, exp_mask, rd}) begin failures++; $display("FAIL rr_beat tenure=%0d beat=%0d got=%h exp=%h", t, b, {bus.s_cyc_o, bus.m_ack_o, bus.m_dat_o}, {1'b1, exp_mask, rd}); end
                tick();
            end
            bus.s_ack_i = 1'b0;
            set_master(g, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
            tick();
            checks++; if (bus.s_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_gap_cyc tenure=%0d got=%b exp=0", t, bus.s_cyc_o); end
            bus.m_cyc_i[g] = 1'b1;
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_no_preempt();
        logic [N-1:0] exp_mask;
        int nxt;
        for (int sc = 0; sc < 2; sc++) begin
            do_reset();
            set_master(2, 1'b1, 1'b1, 1'b1, 2'd1, 8'h5A);
            tick();
            checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL np_first_gnt sc=%0d got=%h exp=4", sc, bus.gnt_o); end
            bus.m_cyc_i[0] = 1'b1;
            if (sc == 0) bus.m_cyc_i[3] = 1'b1;
            sb_q.push_back((sc == 0) ? 3 : 0);
            for (int c = 0; c < 4; c++) begin
                tick();
                checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL np_hold sc=%0d cyc=%0d got=%h exp=4", sc, c, bus.gnt_o); end
            end
            set_master(2, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
            tick();
            tick();
            nxt = int'(sb_q.pop_front());
            exp_mask = '0;
            exp_mask[nxt] = 1'b1;
            checks++; if (bus.gnt_o !== exp_mask) begin failures++; $display("FAIL np_next sc=%0d got=%h exp=%h", sc, bus.gnt_o, exp_mask); end
            idle_inputs();
            tick();
            tick();
        end
    endtask

    task automatic test_read();
        logic [31:0] exp;
        do_reset();
        set_master(1, 1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
        tick();
        bus.s_dat_i = 8'h3C;
        sb_q.push_back(32'h3C);
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m_ack_o !== 4'b0010) begin failures++; $display("FAIL read_ack got=%h exp=2", bus.m_ack_o); end
        exp = sb_q.pop_front();
        checks++; if ({24'd0, bus.m_dat_o} !== exp) begin failures++; $display("FAIL read_data got=%h exp=%h", bus.m_dat_o, exp); end
        checks++; if ({bus.s_we_o, bus.s_adr_o} !== 3'b011) begin failures++; $display("FAIL read_we_adr got=%b exp=011", {bus.s_we_o, bus.s_adr_o}); end
        tick();
        bus.s_ack_i = 1'b0;
        set_master(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m_ack_o !== 4'b0000) begin failures++; $display("FAIL idle_ack_ignored got=%h exp=0", bus.m_ack_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] exp_mask;
        int nxt;
        do_reset();
        bus.m_cyc_i[1] = 1'b1;
        tick();
        bus.m_cyc_i[1] = 1'b0;
        tick();
        set_master(3, 1'b1, 1'b1, 1'b1, 2'd2, 8'h77);
        tick();
        checks++; if (bus.gnt_o !== 4'b1000) begin failures++; $display("FAIL rstmid_gnt got=%h exp=8", bus.gnt_o); end
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m_ack_o !== 4'b1000) begin failures++; $display("FAIL rstmid_ack_before got=%h exp=8", bus.m_ack_o); end
        #1;
        rst_i = 1'b0;
        #1;
        checks++; if ({bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.m_ack_o, bus.busy_o} !== 11'd0) begin failures++; $display("FAIL rstmid_async_drop got=%h exp=0", {bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.m_ack_o, bus.busy_o}); end
        idle_inputs();
        tick();
        rst_i = 1'b1;
        bus.m_cyc_i = 4'hF;
        sb_q.push_back(0);
        tick();
        nxt = int'(sb_q.pop_front());
        exp_mask = '0;
        exp_mask[nxt] = 1'b1;
        checks++; if (bus.gnt_o !== exp_mask) begin failures++; $display("FAIL rstmid_ptr_cleared got=%h exp=%h", bus.gnt_o, exp_mask); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int stall_cycles;
        int err_pulses;
        int gnt_bad;
        logic dropped;
        logic [N-1:0] err_seen;
        do_reset();
        set_master(0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h11);
`ifdef WB_ARB_TIMEOUT_EN
        sb_q.push_back(32'h1);
`endif
        tick();
        stall_cycles = 0;
        err_pulses   = 0;
        gnt_bad      = 0;
        dropped      = 1'b0;
        err_seen     = '0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) bus.m_cyc_i[1] = 1'b1;
            if (bus.s_cyc_o && !dropped) stall_cycles++;
            if (!bus.s_cyc_o) dropped = 1'b1;
            if (bus.m_err_o != '0) begin
                err_pulses++;
                err_seen = bus.m_err_o;
            end
            if (bus.gnt_o !== 4'b0001) gnt_bad++;
            tick();
        end
        checks++; if (gnt_bad !== 0) begin failures++; $display("FAIL to_no_regrant got=%0d exp=0", gnt_bad); end
`ifdef WB_ARB_TIMEOUT_EN
        checks++; if (err_pulses !== 1) begin failures++; $display("FAIL to_err_pulses got=%0d exp=1", err_pulses); end
        checks++; if (32'(err_seen) !== sb_q.pop_front()) begin failures++; $display("FAIL to_err_mask got=%h exp=1", err_seen); end
        checks++; if (stall_cycles !== TO) begin failures++; $display("FAIL to_stall_len got=%0d exp=%0d", stall_cycles, TO); end
        checks++; if ({bus.s_cyc_o, bus.busy_o} !== 2'b01) begin failures++; $display("FAIL to_abort_bus got=%b exp=01", {bus.s_cyc_o, bus.busy_o}); end
        set_master(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL to_release got=%h exp=0", bus.gnt_o); end
        tick();
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL to_next_gnt got=%h exp=2", bus.gnt_o); end
`else
        checks++; if (err_pulses !== 0) begin failures++; $display("FAIL to_err_tied got=%0d exp=0", err_pulses); end
        checks++; if (stall_cycles !== 40) begin failures++; $display("FAIL to_stall_persists got=%0d exp=40", stall_cycles); end
        checks++; if ({bus.s_cyc_o, bus.s_stb_o} !== 2'b11) begin failures++; $display("FAIL to_still_owned got=%b exp=11", {bus.s_cyc_o, bus.s_stb_o}); end
`endif
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_no_preempt();
        test_read();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Synthesizable N-to-1 Wishbone round-robin arbiter.
- Shares the single WB slave port of the I2CMB DUT between several masters, e.g. the test sequencer, an interrupt-service agent and a register-poll agent.
- Grants whole WB cycles (cyc-framed tenure), not single strobes, so a master keeps the bus for multi-beat register sequences.
- Sits between the master agents and the DUT WB slave port.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- ADDR_WIDTH, 2, WB address width.
- DATA_WIDTH, 8, WB data width.
- TIMEOUT_CYCLES, 64, stalled-strobe limit (used only with WB_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data, packed the same way.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master timeout error.
- m_dat_o  out  DATA_WIDTH  read data broadcast to all masters.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  DATA_WIDTH  slave read data.
- gnt_o  out  NUM_MASTERS  one-hot current grant.
- busy_o  out  1  bus owned.

Behaviour:
- Reset (rst_i low, async): state IDLE; gnt_o=0; busy_o=0; s_cyc_o=s_stb_o=s_we_o=0; s_adr_o=0; s_dat_o=0; m_ack_o=0; m_err_o=0; rr pointer ptr=0.
- Reset mid-cycle: grant drops immediately, with no handshake completion. A pending slave ack is not forwarded.
- FSM states: IDLE, OWN, ABORT (ABORT exists only with the optional feature).
- IDLE:
  - If any m_cyc_i is high, select the first index k searching ptr, ptr+1, ..., wrapping modulo NUM_MASTERS.
  - Register gnt_o=onehot(k) and move to OWN.
  - Latency: request sampled at edge E, then gnt_o, busy_o and s_cyc_o are high after E.
- OWN:
  - s_cyc_o=1.
  - s_stb_o, s_we_o, s_adr_o, s_dat_o are combinational muxes from master g.
  - m_ack_o[g]=s_ack_i; all other m_ack_o bits are 0.
  - m_dat_o=s_dat_i at all times.
- Leaving OWN:
  - When m_cyc_i[g] is sampled low, go to IDLE, set gnt_o=0, and set ptr=(g+1) mod NUM_MASTERS.
  - This gives one mandatory dead cycle (s_cyc_o=0) between tenures.
- Outside OWN:
  - s_ack_i is ignored; m_ack_o=0.
  - s_* outputs hold their reset values.
- Arbitration rules:
  - Requests from non-granted masters never preempt the owner.
  - A request that rises at the same edge as the owner's release is considered in the following IDLE cycle.
  - Fairness: a continuously requesting master waits at most NUM_MASTERS-1 tenures.
  - Requests are level-sensitive. A master that drops m_cyc_i before being granted is simply not granted; no state is kept.
- gnt_o is always one-hot or zero. busy_o = (state != IDLE).

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each OWN cycle in which s_stb_o=1 and s_ack_i=0.
  - The counter clears on s_ack_i or when leaving OWN.
  - When the counter reaches TIMEOUT_CYCLES: pulse m_err_o[g] for 1 cycle, force s_cyc_o=s_stb_o=0, enter ABORT.
  - ABORT holds gnt_o and ignores s_ack_i until m_cyc_i[g] is low, then goes to IDLE with ptr=g+1.
- Without the macro: no counter, no ABORT state, m_err_o tied to 0, TIMEOUT_CYCLES unused.

Test Plan:
- Reset then single request: m_cyc_i=4'b0010 at edge 5.
  - Required: gnt_o=4'b0010 and s_cyc_o=1 from edge 6.
  - Write adr=2, dat=8'hA5 appears on s_adr_o/s_dat_o; m_ack_o[1] mirrors s_ack_i.
- All four request continuously (m_cyc_i=4'hF), each holding cyc for 3 beats.
  - Required grant order 0,1,2,3,0 with exactly one s_cyc_o=0 cycle between tenures.
- Owner 2 mid-burst while master 0 raises m_cyc_i: no preemption, gnt_o stays 4'b0100.
  - After master 2 drops cyc: next grant is master 3 if requesting, else master 0.
- Read through the arbiter: slave returns s_dat_i=8'h3C with s_ack_i. Required: m_dat_o=8'h3C and only m_ack_o[g] high.
- Assert rst_i low while owning mid-strobe. Required: s_cyc_o, s_stb_o, gnt_o and m_ack_o go 0 without waiting for a clock; after release, ptr=0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks.
  - Required: m_err_o[g] pulses exactly once, s_cyc_o drops, and no re-grant until m_cyc_i[g] falls.
  - Without the macro: m_err_o stays 0 and the stall persists.
